u8_display_driver: RTL and testbench

Downstream consumer of the unsigned up/down counter's 8-bit `q` output. Continuously converts the unsigned byte to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine. Drives a time-multiplexed, common-anode, 3-digit seven-segment display with leading-zero blanking. Also exposes the packed BCD result and a conversion-done strobe for other logic.

---
 rtl/u8_display_driver.sv | 132 +++++++++++++
 tb/tb_u8_display_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/u8_display_driver.sv
// rtl/u8_display_driver.sv - byte to 3-digit BCD converter driving a multiplexed 7-segment display
// Free-running double-dabble converter plus independent digit scan with leading-zero blanking.
module u8_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        done,
  output logic        busy,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_SHIFT = 2'd1;
  localparam logic [1:0]  S_DONE  = 2'd2;
  localparam logic [19:0] DIV_MAX = 20'(SCAN_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [19:0] work_q, work_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        done_q, done_d;
  logic [19:0] div_q;
  logic [1:0]  dig_q;
  logic [19:0] adj;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    // Nibble-local add-3; carries never cross nibbles since each stays <= 12.
    adj = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8]), work_q[7:0]};
    case (state_q)
      S_IDLE: begin
        work_d  = {12'd0, value};
        cnt_d   = 3'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        work_d = adj << 1;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = work_q[19:8];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      work_q  <= 20'd0;
      cnt_q   <= 3'd0;
      bcd_q   <= 12'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= 20'd0;
      dig_q <= 2'd0;
    end else if (div_q == DIV_MAX) begin
      div_q <= 20'd0;
      dig_q <= (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end else begin
      div_q <= div_q + 20'd1;
    end
  end

  always_comb begin
    an    = 3'b110;
    nib   = bcd_q[3:0];
    blank = 1'b0;
    case (dig_q)
      2'd1: begin
        an    = 3'b101;
        nib   = bcd_q[7:4];
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        an    = 3'b011;
        nib   = bcd_q[11:8];
        blank = (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg = blank ? 7'b1111111 : seg_lut(nib);
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_u8_display_driver.sv
// tb/tb_u8_display_driver.sv - self-checking bench for u8_display_driver
// Table of values with expected BCD/segments plus hand-written reset and timing sequences.
module tb_u8_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  value = 8'd0;
  logic [11:0] bcd;
  logic        done;
  logic        busy;
  logic [2:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  u8_display_driver #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] b;
    logic [6:0]  s2;
    logic [6:0]  s1;
    logic [6:0]  s0;
  } vec_t;

  vec_t vecs[8];
  logic [2:0] an_pat[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    tick();
    while (!done && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  task automatic wait_an(input logic [2:0] exp);
    int n;
    n = 0;
    while (an !== exp && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (an !== exp) begin
      errors++;
      $display("FAIL wait_an: got %b expected %b", an, exp);
    end
  endtask

  initial begin
    an_pat[0] = 3'b110;
    an_pat[1] = 3'b101;
    an_pat[2] = 3'b011;
    vecs[0] = '{8'd255, 12'h255, 7'b0100100, 7'b0010010, 7'b0010010};
    vecs[1] = '{8'd0,   12'h000, 7'b1111111, 7'b1111111, 7'b1000000};
    vecs[2] = '{8'd7,   12'h007, 7'b1111111, 7'b1111111, 7'b1111000};
    vecs[3] = '{8'd105, 12'h105, 7'b1111001, 7'b1000000, 7'b0010010};
    vecs[4] = '{8'd42,  12'h042, 7'b1111111, 7'b0011001, 7'b0100100};
    vecs[5] = '{8'd99,  12'h099, 7'b1111111, 7'b0010000, 7'b0010000};
    vecs[6] = '{8'd100, 12'h100, 7'b1111001, 7'b1000000, 7'b1000000};
    vecs[7] = '{8'd200, 12'h200, 7'b0100100, 7'b1000000, 7'b1000000};

    // Reset state, then release with 255 held; sample i is just after edge R+i.
    rst   = 1'b0;
    value = 8'd255;
    tick();
    tick();
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin
        chk("rst_seg", seg, 7'b1000000);
        rst = 1'b1;
      end
      chk("scan_an", an, an_pat[(i / 4) % 3]);
      chk("done_timing", done, (i == 10 || i == 20) ? 1 : 0);
      chk("busy_timing", busy, (i % 10 == 0) ? 0 : 1);
      chk("bcd_timing", bcd, (i >= 10) ? 12'h255 : 12'h000);
      tick();
    end

    // Table-driven conversions and per-digit segment decode.
    for (int k = 0; k < 8; k++) begin
      value = vecs[k].v;
      wait_done();
      wait_done();
      chk("tbl_bcd", bcd, vecs[k].b);
      wait_an(3'b011);
      chk("tbl_seg_h", seg, vecs[k].s2);
      wait_an(3'b101);
      chk("tbl_seg_t", seg, vecs[k].s1);
      wait_an(3'b110);
      chk("tbl_seg_o", seg, vecs[k].s0);
    end

    // value changes 100 -> 200 while shifting.
    wait_done();
    value = 8'd100;
    tick();
    tick();
    tick();
    value = 8'd200;
    wait_done();
    chk("mid_change_cur", bcd, 12'h100);
    wait_done();
    chk("mid_change_next", bcd, 12'h200);

    // Reset pulse during the 5th SHIFT cycle of converting 99 over 0x042.
    value = 8'd42;
    wait_done();
    wait_done();
    chk("pre_abort_bcd", bcd, 12'h042);
    value = 8'd99;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_busy", busy, 1);
    rst = 1'b0;
    tick();
    chk("abort_bcd", bcd, 12'h000);
    chk("abort_done", done, 0);
    chk("abort_an", an, 3'b110);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("post_abort_done", done, (i == 10) ? 1 : 0);
      chk("post_abort_bcd", bcd, (i == 10) ? 12'h099 : 12'h000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
